uart_fifo_cmd_ctrl: RTL and testbench

Parametrised command controller between a UART RX/TX pair and a synchronous FIFO. Decodes single-byte commands from UART RX:
- fill FIFO until full, or write N pattern words;
- drain FIFO until empty, or read N words to UART TX;
- report FIFO occupancy;
- clear the pattern generator.

It is the next generation of the team's UART-to-FIFO test controller. It adds burst counts, a configurable pattern step, a status command and error signalling.

---
 rtl/uart_fifo_cmd_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_fifo_cmd_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_cmd_ctrl.sv
// uart_fifo_cmd_ctrl: decodes single-byte UART commands into FIFO fill/drain bursts and status reports.
// Define UART_FIFO_CMD_CTRL_ACK_EN to send "!" after every write/read/count command completes.
module uart_fifo_cmd_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4,
    parameter int STEP      = 1
) (
    input  logic                 clk_in,
    input  logic                 n_rst,
    input  logic                 uart_rx_valid_in,
    input  logic [DATA_BITS-1:0] uart_rx_data_in,
    input  logic                 uart_tx_ready_in,
    input  logic                 fifo_empty_in,
    input  logic                 fifo_full_in,
    input  logic [ADDR_BITS:0]   fifo_count_in,
    input  logic [DATA_BITS-1:0] fifo_rd_data_in,
    output logic                 fifo_wr_en,
    output logic [DATA_BITS-1:0] fifo_wr_data_out,
    output logic                 fifo_rd_en,
    output logic                 uart_tx_en,
    output logic [DATA_BITS-1:0] uart_tx_data_out,
    output logic                 busy_out,
    output logic                 err_out
);
    localparam logic [DATA_BITS-1:0] CMD_FILL    = DATA_BITS'('h77);
    localparam logic [DATA_BITS-1:0] CMD_DRAIN   = DATA_BITS'('h72);
    localparam logic [DATA_BITS-1:0] CMD_WRITE_N = DATA_BITS'('h57);
    localparam logic [DATA_BITS-1:0] CMD_READ_N  = DATA_BITS'('h52);
    localparam logic [DATA_BITS-1:0] CMD_STATUS  = DATA_BITS'('h73);
    localparam logic [DATA_BITS-1:0] CMD_CLEAR   = DATA_BITS'('h63);

`ifdef UART_FIFO_CMD_CTRL_ACK_EN
    typedef enum logic [2:0] {IDLE, GET_COUNT, WRITE, READ, STATUS, ACK} state_t;
    localparam state_t DONE = ACK;
`else
    typedef enum logic [2:0] {IDLE, GET_COUNT, WRITE, READ, STATUS} state_t;
    localparam state_t DONE = IDLE;
`endif

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] wr_counter_q, wr_counter_d;
    logic [DATA_BITS-1:0] remaining_q, remaining_d;
    logic                 mode_q, mode_d;
    logic                 dir_q, dir_d;
    logic                 err;
    logic                 last;

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            wr_counter_q <= '0;
            remaining_q  <= '0;
            mode_q       <= 1'b0;
            dir_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_counter_q <= wr_counter_d;
            remaining_q  <= remaining_d;
            mode_q       <= mode_d;
            dir_q        <= dir_d;
        end
    end

    // mode_q: 1 = count burst, 0 = run until FIFO full/empty; dir_q: 1 = write burst
    always_comb begin
        state_d          = state_q;
        wr_counter_d     = wr_counter_q;
        remaining_d      = remaining_q;
        mode_d           = mode_q;
        dir_d            = dir_q;
        fifo_wr_en       = 1'b0;
        fifo_rd_en       = 1'b0;
        uart_tx_en       = 1'b0;
        uart_tx_data_out = fifo_rd_data_in;
        err              = uart_rx_valid_in && state_q != IDLE && state_q != GET_COUNT;
        last             = mode_q && remaining_q == DATA_BITS'(1);
        case (state_q)
            IDLE: if (uart_rx_valid_in) begin
                if (uart_rx_data_in == CMD_FILL || uart_rx_data_in == CMD_DRAIN) begin
                    mode_d  = 1'b0;
                    state_d = (uart_rx_data_in == CMD_FILL) ? WRITE : READ;
                end else if (uart_rx_data_in == CMD_WRITE_N || uart_rx_data_in == CMD_READ_N) begin
                    dir_d   = uart_rx_data_in == CMD_WRITE_N;
                    state_d = GET_COUNT;
                end else if (uart_rx_data_in == CMD_STATUS) begin
                    state_d = STATUS;
                end else if (uart_rx_data_in == CMD_CLEAR) begin
                    wr_counter_d = '0;
                end else begin
                    err = 1'b1;
                end
            end
            GET_COUNT: if (uart_rx_valid_in) begin
                remaining_d = uart_rx_data_in;
                mode_d      = 1'b1;
                state_d     = (uart_rx_data_in == '0) ? DONE : (dir_q ? WRITE : READ);
            end
            WRITE: if (fifo_full_in) begin
                state_d = DONE;
                err     = err | mode_q;
            end else begin
                fifo_wr_en   = 1'b1;
                wr_counter_d = wr_counter_q + DATA_BITS'(STEP);
                remaining_d  = mode_q ? remaining_q - DATA_BITS'(1) : remaining_q;
                state_d      = last ? DONE : WRITE;
            end
            READ: if (fifo_empty_in) begin
                state_d = DONE;
                err     = err | (mode_q && remaining_q != '0);
            end else if (uart_tx_ready_in) begin
                fifo_rd_en  = 1'b1;
                uart_tx_en  = 1'b1;
                remaining_d = mode_q ? remaining_q - DATA_BITS'(1) : remaining_q;
                state_d     = last ? DONE : READ;
            end
            STATUS: if (uart_tx_ready_in) begin
                uart_tx_en       = 1'b1;
                uart_tx_data_out = DATA_BITS'(fifo_count_in);
                state_d          = IDLE;
            end
`ifdef UART_FIFO_CMD_CTRL_ACK_EN
            ACK: if (uart_tx_ready_in) begin
                uart_tx_en       = 1'b1;
                uart_tx_data_out = DATA_BITS'('h21);
                state_d          = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign fifo_wr_data_out = wr_counter_q;
    assign busy_out         = state_q != IDLE;
    assign err_out          = n_rst & err;
endmodule

// File: tb/tb_uart_fifo_cmd_ctrl.sv
// tb_uart_fifo_cmd_ctrl: table, directed and random command tests against a transaction-level model
// with a 16-deep show-ahead FIFO model in the environment.
module tb_uart_fifo_cmd_ctrl;
    localparam int STEP  = 3;
    localparam int DEPTH = 16;
`ifdef UART_FIFO_CMD_CTRL_ACK_EN
    localparam int ACK = 1;
`else
    localparam int ACK = 0;
`endif

    logic       clk_in = 0, n_rst = 0;
    logic       uart_rx_valid_in = 0, uart_tx_ready_in = 1;
    logic [7:0] uart_rx_data_in = 0, fifo_rd_data_in = 0;
    logic       fifo_empty_in = 1, fifo_full_in = 0;
    logic [4:0] fifo_count_in = 0;
    logic       fifo_wr_en, fifo_rd_en, uart_tx_en, busy_out, err_out;
    logic [7:0] fifo_wr_data_out, uart_tx_data_out;

    uart_fifo_cmd_ctrl #(.DATA_BITS(8), .ADDR_BITS(4), .STEP(STEP)) dut (
        .clk_in(clk_in), .n_rst(n_rst),
        .uart_rx_valid_in(uart_rx_valid_in), .uart_rx_data_in(uart_rx_data_in),
        .uart_tx_ready_in(uart_tx_ready_in),
        .fifo_empty_in(fifo_empty_in), .fifo_full_in(fifo_full_in),
        .fifo_count_in(fifo_count_in), .fifo_rd_data_in(fifo_rd_data_in),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data_out(fifo_wr_data_out),
        .fifo_rd_en(fifo_rd_en), .uart_tx_en(uart_tx_en),
        .uart_tx_data_out(uart_tx_data_out), .busy_out(busy_out), .err_out(err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] n;
        int rm;
        int e_wr;
        int e_tx;
        int e_err;
    } vec_t;

    logic [7:0] q[$];
    logic [7:0] wr_log[$];
    logic [7:0] tx_log[$];
    int         xfer_cyc[$];
    int         cyc = 0, err_cnt = 0, both_cnt = 0, rmode = 0;
    int         total = 0, bad = 0;
    logic [7:0] m_ctr = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_fifo();
        fifo_empty_in   = q.size() == 0;
        fifo_full_in    = q.size() == DEPTH;
        fifo_count_in   = 5'(q.size());
        fifo_rd_data_in = (q.size() > 0) ? q[0] : 8'h00;
    endtask

    task automatic drive_ready();
        case (rmode)
            0: uart_tx_ready_in = 1'b1;
            1: uart_tx_ready_in = ~uart_tx_ready_in;
            2: uart_tx_ready_in = 1'($urandom_range(0, 1));
            default: uart_tx_ready_in = 1'b0;
        endcase
    endtask

    task automatic cycle();
        @(negedge clk_in);
        if (fifo_wr_en && fifo_rd_en) both_cnt++;
        if (fifo_wr_en) begin
            wr_log.push_back(fifo_wr_data_out);
            xfer_cyc.push_back(cyc);
            if (q.size() < DEPTH) q.push_back(fifo_wr_data_out);
        end
        if (fifo_rd_en) begin
            xfer_cyc.push_back(cyc);
            if (q.size() > 0) void'(q.pop_front());
        end
        if (uart_tx_en) tx_log.push_back(uart_tx_data_out);
        if (err_out) err_cnt++;
        cyc++;
        @(posedge clk_in);
        #1;
        uart_rx_valid_in = 1'b0;
        set_fifo();
        drive_ready();
    endtask

    task automatic send(input logic [7:0] b);
        uart_rx_valid_in = 1'b1;
        uart_rx_data_in  = b;
        cycle();
    endtask

    task automatic clear_logs();
        wr_log.delete();
        tx_log.delete();
        xfer_cyc.delete();
        err_cnt  = 0;
        both_cnt = 0;
    endtask

    task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] n, input int rm,
                           input int inj, input string tag);
        logic [7:0] exp_wr[$];
        logic [7:0] exp_tx[$];
        int pre, free, nw, nrd, exp_err, c0, k, wbad, tbad;
        bit has_n, xfer;
        pre     = q.size();
        free    = DEPTH - pre;
        nw      = 0;
        nrd     = 0;
        exp_err = 0;
        has_n   = cmd == 8'h57 || cmd == 8'h52;
        xfer    = has_n || cmd == 8'h77 || cmd == 8'h72;
        case (cmd)
            8'h77: nw = free;
            8'h57: begin nw = (int'(n) < free) ? int'(n) : free; exp_err = int'(int'(n) > free); end
            8'h72: nrd = pre;
            8'h52: begin nrd = (int'(n) < pre) ? int'(n) : pre; exp_err = int'(int'(n) > pre); end
            8'h73: exp_tx.push_back(8'(pre));
            8'h63: m_ctr = 8'h00;
            default: exp_err = 1;
        endcase
        for (int i = 0; i < nrd; i++) exp_tx.push_back(q[i]);
        for (int i = 0; i < nw; i++) exp_wr.push_back(8'(int'(m_ctr) + i * STEP));
        m_ctr = 8'(int'(m_ctr) + nw * STEP);
        if (ACK == 1 && xfer) exp_tx.push_back(8'h21);
        if (inj > 0) exp_err++;
        clear_logs();
        rmode = rm;
        drive_ready();
        c0 = cyc;
        send(cmd);
        if (has_n) send(n);
        k = 0;
        while (busy_out && k < 300) begin
            if (inj > 0 && k == inj) begin
                uart_rx_valid_in = 1'b1;
                uart_rx_data_in  = 8'h78;
            end
            cycle();
            k++;
        end
        chk({tag, " idle"}, int'(busy_out), 0);
        chk({tag, " wr_n"}, wr_log.size(), exp_wr.size());
        wbad = -1;
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
            if (wbad < 0 && wr_log[i] !== exp_wr[i]) wbad = i;
        chk({tag, " wr_data first bad index"}, wbad, -1);
        chk({tag, " tx_n"}, tx_log.size(), exp_tx.size());
        tbad = -1;
        for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
            if (tbad < 0 && tx_log[i] !== exp_tx[i]) tbad = i;
        chk({tag, " tx_data first bad index"}, tbad, -1);
        chk({tag, " err"}, err_cnt, exp_err);
        chk({tag, " wr_rd_overlap"}, both_cnt, 0);
        chk({tag, " wr_counter"}, int'(fifo_wr_data_out), int'(m_ctr));
        if (rm == 0 && nw + nrd > 0 && xfer_cyc.size() > 0) begin
            chk({tag, " latency"}, xfer_cyc[0] - c0, has_n ? 2 : 1);
            chk({tag, " no_bubbles"}, xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[0], nw + nrd - 1);
        end
    endtask

    initial begin
        vec_t tbl[15];
        int k;
        logic [7:0] cmds[7];
        tbl[0]  = '{8'h77, 8'd0,   0, 16, 0,  0};
        tbl[1]  = '{8'h72, 8'd0,   1, 0,  16, 0};
        tbl[2]  = '{8'h63, 8'd0,   0, 0,  0,  0};
        tbl[3]  = '{8'h57, 8'd5,   0, 5,  0,  0};
        tbl[4]  = '{8'h73, 8'd0,   2, 0,  1,  0};
        tbl[5]  = '{8'h52, 8'd2,   0, 0,  2,  0};
        tbl[6]  = '{8'h52, 8'd6,   1, 0,  3,  1};
        tbl[7]  = '{8'h57, 8'd0,   0, 0,  0,  0};
        tbl[8]  = '{8'h41, 8'd0,   0, 0,  0,  1};
        tbl[9]  = '{8'h57, 8'd20,  2, 16, 0,  1};
        tbl[10] = '{8'h57, 8'd16,  0, 0,  0,  1};
        tbl[11] = '{8'h77, 8'd0,   0, 0,  0,  0};
        tbl[12] = '{8'h72, 8'd0,   2, 0,  16, 0};
        tbl[13] = '{8'h52, 8'd255, 0, 0,  0,  1};
        tbl[14] = '{8'h72, 8'd0,   0, 0,  0,  0};
        cmds = '{8'h77, 8'h72, 8'h57, 8'h52, 8'h73, 8'h63, 8'h41};

        set_fifo();
        uart_rx_valid_in = 1'b1;
        uart_rx_data_in  = 8'h41;
        #3;
        chk("rst busy", int'(busy_out), 0);
        chk("rst wr_en", int'(fifo_wr_en), 0);
        chk("rst rd_en", int'(fifo_rd_en), 0);
        chk("rst tx_en", int'(uart_tx_en), 0);
        chk("rst err", int'(err_out), 0);
        chk("rst wr_data", int'(fifo_wr_data_out), 0);
        uart_rx_valid_in = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        n_rst = 1'b1;
        #1;
        chk("post_rst busy", int'(busy_out), 0);
        chk("post_rst err", int'(err_out), 0);

        for (int i = 0; i < 15; i++) begin
            run_cmd(tbl[i].cmd, tbl[i].n, tbl[i].rm, 0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d exp_wr", i), wr_log.size(), tbl[i].e_wr);
            chk($sformatf("tbl%0d exp_tx", i), tx_log.size(),
                tbl[i].e_tx + ((tbl[i].cmd inside {8'h77, 8'h72, 8'h57, 8'h52}) ? ACK : 0));
            chk($sformatf("tbl%0d exp_err", i), err_cnt, tbl[i].e_err);
        end

        // status held off by a stalled transmitter
        run_cmd(8'h57, 8'd7, 0, 0, "pre_status");
        clear_logs();
        rmode = 3;
        drive_ready();
        send(8'h73);
        for (int i = 0; i < 4; i++) cycle();
        chk("status stalled tx", tx_log.size(), 0);
        chk("status stalled busy", int'(busy_out), 1);
        rmode = 0;
        drive_ready();
        k = 0;
        while (busy_out && k < 20) begin cycle(); k++; end
        chk("status idle", int'(busy_out), 0);
        chk("status tx_n", tx_log.size(), 1);
        if (tx_log.size() > 0) chk("status byte", int'(tx_log[0]), 7);

        // stray byte during a fill
        run_cmd(8'h77, 8'd0, 0, 3, "fill_inj");
        run_cmd(8'h72, 8'd0, 0, 0, "drain");

        // asynchronous reset in the middle of a count burst
        clear_logs();
        rmode = 0;
        send(8'h57);
        send(8'h0A);
        k = 0;
        while (wr_log.size() < 4 && k < 50) begin cycle(); k++; end
        chk("rst_mid writes", wr_log.size(), 4);
        chk("rst_mid active", int'(fifo_wr_en), 1);
        #1;
        n_rst = 1'b0;
        #1;
        chk("rst_mid wr_en", int'(fifo_wr_en), 0);
        chk("rst_mid busy", int'(busy_out), 0);
        chk("rst_mid wr_data", int'(fifo_wr_data_out), 0);
        uart_rx_valid_in = 1'b1;
        uart_rx_data_in  = 8'h41;
        #1;
        chk("rst_mid err", int'(err_out), 0);
        cycle();
        cycle();
        n_rst = 1'b1;
        #1;
        chk("rst_mid released busy", int'(busy_out), 0);
        chk("rst_mid err_cnt", err_cnt, 0);
        chk("rst_mid writes held", wr_log.size(), 4);
        m_ctr = 8'h00;
        run_cmd(8'h77, 8'd0, 0, 0, "after_rst_fill");

        for (int i = 0; i < 40; i++)
            run_cmd(cmds[$urandom_range(0, 6)], 8'($urandom_range(0, 20)),
                    int'($urandom_range(0, 2)), 0, $sformatf("rnd%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
